cond_unit_pipe: RTL
===================

# cond_unit_pipe

Parametrised conditional-execution unit for the pipelined ARMv4 core, succeeding the single-cycle conditional logic. It holds the architectural NZCV flag register and evaluates all 16 ARMv4 condition codes against the stored flags. It gates the Execute-stage write/branch enables and registers them into the Memory stage. It also honours stall/flush, and keeps executed/squashed instruction counters for performance monitoring.

## Interface
Parameters:
- CNT_W, 16, width of both performance counters
- SAT, 1, 1 = counters saturate at all-ones, 0 = counters wrap to 0
- OUT_REG, 1, 1 = M-stage outputs registered, 0 = M-stage outputs combinational copies of E-stage gated enables

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- ValidE  in  1  an instruction occupies Execute
- StallE  in  1  hold Execute this cycle
- FlushE  in  1  kill the Execute instruction
- CondE  in  4  instruction condition field [31:28]
- ALUFlags  in  4  {N,Z,C,V} from the ALU, this cycle
- PCSE, RegWE, MemWE  in  1 each  decoder requests
- FlagWE  in  2  [1] updates N,Z; [0] updates C,V
- CntClr  in  1  synchronous clear of both counters
- CondExE  out  1  condition passed (combinational, from stored Flags)
- PCSrcE  out  1  gated branch/PC-write, combinational, for fetch redirect
- RegWriteM, MemWriteM, PCSrcM  out  1 each  gated enables for Memory stage
- Flags  out  4  architectural {N,Z,C,V}
- ExecCnt, SquashCnt  out  CNT_W each  performance counters

## Operation
- Condition table on Flags {N,Z,C,V}:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V
  - 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0
- Issue = ValidE & !StallE & !FlushE. FlushE has priority over StallE.
- Gated enables:
  - RegWrE = RegWE & CondExE & Issue
  - MemWrE = MemWE & CondExE & Issue
  - PCSrcE = PCSE & CondExE & Issue
  - FlagWrE[i] = FlagWE[i] & CondExE & Issue
- Flag update:
  - FlagWrE[1]: Flags[3:2] <= ALUFlags[3:2]
  - FlagWrE[0]: Flags[1:0] <= ALUFlags[1:0]
  - Groups with a 0 enable hold.
- Evaluation always uses the stored Flags, never the same-cycle ALUFlags. An instruction's own flag write affects only later instructions.
- M stage (OUT_REG=1): on each edge, RegWriteM/MemWriteM/PCSrcM <= RegWrE/MemWrE/PCSrcE. A stalled or flushed cycle therefore inserts a bubble (all 0), so a held instruction is never issued twice.
- OUT_REG=0: M outputs equal the E-stage gated values combinationally.
- Counters:
  - Issue & CondExE: ExecCnt +1
  - Issue & !CondExE: SquashCnt +1
  - Non-issued cycles: no change
  - SAT=1 holds at 2^CNT_W-1; SAT=0 wraps to 0
  - CntClr sets both to 0 and wins over a same-cycle increment
- reset: Flags=0000, RegWriteM=MemWriteM=PCSrcM=0, ExecCnt=SquashCnt=0. This applies even mid-stall or mid-flush. The combinational outputs follow the reset Flags in the same cycle.

## Timing
- CondExE and PCSrcE: combinational, 0 cycles from CondE/ValidE/StallE/FlushE.
- Flags: visible 1 cycle after the issuing edge. The next instruction in E sees them.
- M enables:
  - OUT_REG=1: 1-cycle latency.
  - OUT_REG=0: 0-cycle latency.
- Counters: updated at the edge ending the issue cycle.
- Back-to-back flag-setting instructions: each sees the flags of its predecessor. There is no ALUFlags bypass.

## Test plan
- Reset with all inputs active -> Flags=0000, all M outputs 0, counters 0. Next cycle CondE=0 (EQ) -> CondExE=0.
- CMP-like op: ValidE=1, FlagWE=11, CondE=14, ALUFlags=0100. Next cycle CondE=0 -> Flags=0100, CondExE=1. Then CondE=1 -> CondExE=0.
- Sweep all 16 CondE codes over all 16 Flags values -> CondExE matches the table. CondE=15 -> always 0, SquashCnt +1.
- Conditional store: CondE=11, N≠V, MemWE=1. With StallE=1 for 2 cycles, then released -> MemWriteM pulses exactly once, 1 cycle after release. ExecCnt +1.
- FlushE=1 & StallE=1 with FlagWE=11, ALUFlags=1111 -> Flags unchanged, all enables 0, counters unchanged.
- CNT_W=2, SAT=1: 5 squashed issues -> SquashCnt=3. With SAT=0 -> SquashCnt=1. CntClr on the same edge as an increment -> 0.

Source files
------------

// File: rtl/cond_unit_pipe.sv
// ARMv4 conditional-execution unit: NZCV flags, condition check,
// E-stage enable gating, M-stage enable register and perf counters.
module cond_unit_pipe #(
  parameter int CNT_W   = 16,
  parameter bit SAT     = 1'b1,
  parameter bit OUT_REG = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ValidE,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic [3:0]       CondE,
  input  logic [3:0]       ALUFlags,
  input  logic             PCSE,
  input  logic             RegWE,
  input  logic             MemWE,
  input  logic [1:0]       FlagWE,
  input  logic             CntClr,
  output logic             CondExE,
  output logic             PCSrcE,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             PCSrcM,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] ExecCnt,
  output logic [CNT_W-1:0] SquashCnt
);

  localparam logic [CNT_W-1:0] CMAX = '1;

  logic       n, z, c, v;
  logic       issue;
  logic       regwre;
  logic       memwre;
  logic [1:0] flagwre;

  assign {n, z, c, v} = Flags;

  always_comb begin
    CondExE = 1'b0;
    unique case (CondE)
      4'd0:  CondExE = z;
      4'd1:  CondExE = ~z;
      4'd2:  CondExE = c;
      4'd3:  CondExE = ~c;
      4'd4:  CondExE = n;
      4'd5:  CondExE = ~n;
      4'd6:  CondExE = v;
      4'd7:  CondExE = ~v;
      4'd8:  CondExE = c & ~z;
      4'd9:  CondExE = ~c | z;
      4'd10: CondExE = n ~^ v;
      4'd11: CondExE = n ^ v;
      4'd12: CondExE = ~z & (n ~^ v);
      4'd13: CondExE = z | (n ^ v);
      4'd14: CondExE = 1'b1;
      4'd15: CondExE = 1'b0;
    endcase
  end

  // flush beats stall simply because either one blocks issue
  assign issue   = ValidE & ~StallE & ~FlushE;
  assign regwre  = RegWE & CondExE & issue;
  assign memwre  = MemWE & CondExE & issue;
  assign PCSrcE  = PCSE & CondExE & issue;
  assign flagwre = FlagWE & {2{CondExE & issue}};

  function automatic logic [CNT_W-1:0] bump(
    input logic [CNT_W-1:0] cnt
  );
    if (SAT && cnt == CMAX) return cnt;
    return cnt + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      Flags     <= 4'b0000;
      ExecCnt   <= '0;
      SquashCnt <= '0;
    end else begin
      if (flagwre[1]) Flags[3:2] <= ALUFlags[3:2];
      if (flagwre[0]) Flags[1:0] <= ALUFlags[1:0];
      if (CntClr) begin
        ExecCnt   <= '0;
        SquashCnt <= '0;
      end else if (issue) begin
        if (CondExE) ExecCnt <= bump(ExecCnt);
        else SquashCnt <= bump(SquashCnt);
      end
    end
  end

  generate
    if (OUT_REG) begin : g_mreg
      always_ff @(posedge clk) begin
        if (reset) begin
          RegWriteM <= 1'b0;
          MemWriteM <= 1'b0;
          PCSrcM    <= 1'b0;
        end else begin
          RegWriteM <= regwre;
          MemWriteM <= memwre;
          PCSrcM    <= PCSrcE;
        end
      end
    end else begin : g_mcomb
      assign RegWriteM = regwre;
      assign MemWriteM = memwre;
      assign PCSrcM    = PCSrcE;
    end
  endgenerate

endmodule
